instr_mix_gen: RTL

INSTR_MIX_GEN -- requirements
Module: instr_mix_gen

---
 rtl/instr_mix_gen.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_mix_gen.sv
// Weighted random instruction-mix generator with RAW/WAW hazard injection.
// Latency: start_i to first valid_o is NUM_CLASSES+1 cycles; then up to one instruction per cycle.
// Backpressure: valid/ready; the presented instruction is held stable until accepted, the LFSR only steps on a load.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start_i, num_instr_i, seed_i   run request, instruction count, LFSR seed (0 is treated as 1)
//   weights_i                      NUM_CLASSES x WEIGHT_W class weights, class 0 in the LSBs
//   raw_rate_i, waw_rate_i         hazard injection percentages, values above 100 saturate
//   valid_o, ready_i               instruction handshake
//   class_o, rd_o, rs1_o, rs2_o    generated instruction fields
//   raw_o, waw_o                   set when a hazard on the previous destination was injected
//   busy_o, done_o, cfg_err_o      run in progress, run-complete pulse, all-zero-weights pulse
//
// The register field mapping takes rd/rs1/rs2 from LFSR bits [16 +: 3*REG_W], so REG_W must be <= 5.
module instr_mix_gen #(
    parameter int NUM_CLASSES = 6,
    parameter int WEIGHT_W    = 8,
    parameter int COUNT_W     = 16,
    parameter int REG_W       = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic [COUNT_W-1:0]              num_instr_i,
    input  logic [31:0]                     seed_i,
    input  logic [NUM_CLASSES*WEIGHT_W-1:0] weights_i,
    input  logic [6:0]                      raw_rate_i,
    input  logic [6:0]                      waw_rate_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [$clog2(NUM_CLASSES)-1:0]  class_o,
    output logic [REG_W-1:0]                rd_o,
    output logic [REG_W-1:0]                rs1_o,
    output logic [REG_W-1:0]                rs2_o,
    output logic                            raw_o,
    output logic                            waw_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            cfg_err_o
);

    localparam int          CLS_W     = $clog2(NUM_CLASSES);
    localparam int          SUM_W     = WEIGHT_W + CLS_W;
    localparam int          PROD_W    = 16 + SUM_W;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [6:0]  RATE_MAX  = 7'd100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_GEN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                              state_q, state_d;
    logic [CLS_W-1:0]                    idx_q, idx_d;
    logic [NUM_CLASSES*WEIGHT_W-1:0]     weights_q, weights_d;
    logic [NUM_CLASSES-1:0][SUM_W-1:0]   cum_q, cum_d;
    logic [COUNT_W-1:0]                  rem_q, rem_d;
    logic [6:0]                          raw_rate_q, raw_rate_d;
    logic [6:0]                          waw_rate_q, waw_rate_d;
    logic [31:0]                         lfsr_q, lfsr_d;
    logic [REG_W-1:0]                    last_rd_q, last_rd_d;
    logic                                have_last_q, have_last_d;

    logic                                valid_q, valid_d;
    logic [CLS_W-1:0]                    class_q, class_d;
    logic [REG_W-1:0]                    rd_q, rd_d;
    logic [REG_W-1:0]                    rs1_q, rs1_d;
    logic [REG_W-1:0]                    rs2_q, rs2_d;
    logic                                raw_q, raw_d;
    logic                                waw_q, waw_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                cfg_err_q, cfg_err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                                accept;
    logic                                load_now;
    logic [SUM_W-1:0]                    prev_sum;
    logic [SUM_W-1:0]                    total;
    logic [PROD_W-1:0]                   pick_prod;
    logic [SUM_W-1:0]                    pick;
    logic [14:0]                         raw_prod, waw_prod;
    logic [6:0]                          draw_raw, draw_waw;
    logic [CLS_W-1:0]                    gen_class;
    logic [REG_W-1:0]                    gen_rd, gen_rs1, gen_rs2;
    logic                                gen_raw, gen_waw;

    assign accept = (state_q == S_GEN) && valid_q && ready_i;

    // Prefix sums: one class per LOAD cycle. cum_d is used directly by the
    // generator so the first instruction can be built in the final LOAD
    // cycle, while the last sum is still on its way into cum_q.
    always_comb begin
        cum_d    = cum_q;
        prev_sum = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if ((state_q == S_LOAD) && (idx_q == CLS_W'(i))) begin
                cum_d[i] = prev_sum + SUM_W'(weights_q[i*WEIGHT_W +: WEIGHT_W]);
            end
            prev_sum = cum_q[i];
        end
    end

    // Hazard history. The next instruction is built in the same cycle the
    // current one is accepted, so it must see the destination being accepted
    // now rather than the registered copy.
    always_comb begin
        last_rd_d   = last_rd_q;
        have_last_d = have_last_q;
        if ((state_q == S_IDLE) && start_i) begin
            last_rd_d   = '0;
            have_last_d = 1'b0;
        end else if (accept) begin
            last_rd_d   = rd_q;
            have_last_d = 1'b1;
        end
    end

    // Instruction generator: a pure function of the current LFSR value,
    // the prefix sums, the rates and the hazard history.
    always_comb begin
        total     = cum_d[NUM_CLASSES-1];
        pick_prod = PROD_W'(lfsr_q[15:0]) * PROD_W'(total);
        pick      = SUM_W'(pick_prod >> 16);

        // Descending scan leaves the smallest matching class. A zero-weight
        // class has cum equal to its predecessor and can never be the first
        // sum above pick.
        gen_class = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (pick < cum_d[i]) begin
                gen_class = CLS_W'(i);
            end
        end

        // Scale an 8-bit draw to 0..99 for comparison against a percentage.
        raw_prod = 15'(lfsr_q[7:0])  * 15'd100;
        waw_prod = 15'(lfsr_q[15:8]) * 15'd100;
        draw_raw = 7'(raw_prod >> 8);
        draw_waw = 7'(waw_prod >> 8);
        gen_raw  = have_last_d && (draw_raw < raw_rate_q);
        gen_waw  = have_last_d && (draw_waw < waw_rate_q);

        gen_rd  = lfsr_q[16 +: REG_W];
        gen_rs1 = lfsr_q[16 + REG_W +: REG_W];
        gen_rs2 = lfsr_q[16 + 2*REG_W +: REG_W];
        if (gen_rd == '0) begin
            gen_rd = REG_W'(1);
        end
        if (gen_raw) begin
            gen_rs1 = last_rd_d;
        end
        if (gen_waw) begin
            gen_rd = last_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM and output register next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        weights_d  = weights_q;
        rem_d      = rem_q;
        raw_rate_d = raw_rate_q;
        waw_rate_d = waw_rate_q;
        lfsr_d     = lfsr_q;
        valid_d    = valid_q;
        class_d    = class_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        raw_d      = raw_q;
        waw_d      = waw_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        load_now   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_LOAD;
                    idx_d      = '0;
                    weights_d  = weights_i;
                    rem_d      = num_instr_i;
                    raw_rate_d = (raw_rate_i > RATE_MAX) ? RATE_MAX : raw_rate_i;
                    waw_rate_d = (waw_rate_i > RATE_MAX) ? RATE_MAX : waw_rate_i;
                    lfsr_d     = (seed_i == 32'd0) ? 32'd1 : seed_i;
                end
            end

            S_LOAD: begin
                if (idx_q == CLS_W'(NUM_CLASSES - 1)) begin
                    if (cum_d[NUM_CLASSES-1] == '0) begin
                        cfg_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (rem_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        load_now = 1'b1;
                        state_d  = S_GEN;
                    end
                end else begin
                    idx_d = idx_q + CLS_W'(1);
                end
            end

            S_GEN: begin
                // rem_q counts the instruction currently presented.
                if (accept) begin
                    if (rem_q > COUNT_W'(1)) begin
                        rem_d    = rem_q - COUNT_W'(1);
                        load_now = 1'b1;
                    end else begin
                        rem_d   = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_now) begin
            valid_d = 1'b1;
            class_d = gen_class;
            rd_d    = gen_rd;
            rs1_d   = gen_rs1;
            rs2_d   = gen_rs2;
            raw_d   = gen_raw;
            waw_d   = gen_waw;
            // Galois right-shift step, one per generated instruction.
            lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            weights_q   <= '0;
            cum_q       <= '0;
            rem_q       <= '0;
            raw_rate_q  <= '0;
            waw_rate_q  <= '0;
            lfsr_q      <= 32'd1;
            last_rd_q   <= '0;
            have_last_q <= 1'b0;
            valid_q     <= 1'b0;
            class_q     <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            raw_q       <= 1'b0;
            waw_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            weights_q   <= weights_d;
            cum_q       <= cum_d;
            rem_q       <= rem_d;
            raw_rate_q  <= raw_rate_d;
            waw_rate_q  <= waw_rate_d;
            lfsr_q      <= lfsr_d;
            last_rd_q   <= last_rd_d;
            have_last_q <= have_last_d;
            valid_q     <= valid_d;
            class_q     <= class_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            raw_q       <= raw_d;
            waw_q       <= waw_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign valid_o   = valid_q;
    assign class_o   = class_q;
    assign rd_o      = rd_q;
    assign rs1_o     = rs1_q;
    assign rs2_o     = rs2_q;
    assign raw_o     = raw_q;
    assign waw_o     = waw_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign cfg_err_o = cfg_err_q;

endmodule
